// File: rtl/tis_pkg.sv
// tis_pkg: shared definitions for the TIS node array.
//   word_t            11-bit signed machine word
//   WORD_MAX/MIN      legal ISA value range (+/-999)
//   NIL..DOWN         port operand codes (1000..1007)
//   sat_word()        clamps a raw 11-bit code into the legal range
package tis_pkg;

  typedef logic signed [10:0] word_t;

  localparam word_t WORD_MAX = 11'sd999;
  localparam word_t WORD_MIN = -11'sd999;

  // Operand codes sit just above the legal data range.
  localparam word_t NIL   = 11'sd1000;
  localparam word_t ACC   = 11'sd1001;
  localparam word_t ANY   = 11'sd1002;
  localparam word_t LAST  = 11'sd1003;
  localparam word_t LEFT  = 11'sd1004;
  localparam word_t RIGHT = 11'sd1005;
  localparam word_t UP    = 11'sd1006;
  localparam word_t DOWN  = 11'sd1007;

  function automatic word_t sat_word(input word_t w);
    word_t r;
    r = w;
    if (w > WORD_MAX) r = WORD_MAX;
    else if (w < WORD_MIN) r = WORD_MIN;
    return r;
  endfunction

endpackage

// File: rtl/tis_link_fifo.sv
// tis_link_fifo: one direction of a TIS link; a small FIFO of saturated words.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wdata, write      writer side word and strobe
//   wready            space available (from registered count only)
//   rdata, rready     head word (0 when empty) and non-empty flag
//   read              consume head
//   count             current occupancy 0..DEPTH
//   ovf, unf          sticky overflow / underflow flags
module tis_link_fifo
  import tis_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  word_t            wdata,
  input  logic             write,
  output logic             wready,
  output word_t            rdata,
  output logic             rready,
  input  logic             read,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  word_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  logic             do_wr, do_rd;

  // Flags come from registered count only: a read on a full FIFO does not
  // open a slot for a write in the same cycle, and a write on an empty FIFO
  // is not visible to the reader until the next cycle.
  assign wready = (count_reg != FULL_CNT);
  assign rready = (count_reg != '0);
  assign do_wr  = write && wready;
  assign do_rd  = read && rready;

  assign rdata  = rready ? mem[rd_ptr_reg] : '0;
  assign count  = count_reg;
  assign ovf    = ovf_reg;
  assign unf    = unf_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg | (write && !wready);
    unf_next    = unf_reg | (read && !rready);
    if (do_wr) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (do_rd) rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({do_wr, do_rd})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  // Storage needs no reset: contents are only observable while count > 0.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= sat_word(wdata);
  end

endmodule

// File: rtl/tis_link.sv
// tis_link: bidirectional channel between adjacent TIS nodes A and B.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_wdata/a_write/a_wready    A's output port into the A->B FIFO
//   a_rdata/a_rready/a_read     A's input port from the B->A FIFO
//   b_wdata/b_write/b_wready    B's output port into the B->A FIFO
//   b_rdata/b_rready/b_read     B's input port from the A->B FIFO
//   ab_count, ba_count          per-direction occupancy
//   err                         sticky {underflow, overflow}, either direction
module tis_link
  import tis_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  word_t            a_wdata,
  input  logic             a_write,
  output logic             a_wready,
  output word_t            a_rdata,
  output logic             a_rready,
  input  logic             a_read,
  input  word_t            b_wdata,
  input  logic             b_write,
  output logic             b_wready,
  output word_t            b_rdata,
  output logic             b_rready,
  input  logic             b_read,
  output logic [CNT_W-1:0] ab_count,
  output logic [CNT_W-1:0] ba_count,
  output logic [1:0]       err
);

  logic ab_ovf, ab_unf, ba_ovf, ba_unf;

  tis_link_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ab (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (a_wdata),
    .write  (a_write),
    .wready (a_wready),
    .rdata  (b_rdata),
    .rready (b_rready),
    .read   (b_read),
    .count  (ab_count),
    .ovf    (ab_ovf),
    .unf    (ab_unf)
  );

  tis_link_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_ba (
    .clk    (clk),
    .rst_n  (rst_n),
    .wdata  (b_wdata),
    .write  (b_write),
    .wready (b_wready),
    .rdata  (a_rdata),
    .rready (a_rready),
    .read   (a_read),
    .count  (ba_count),
    .ovf    (ba_ovf),
    .unf    (ba_unf)
  );

  assign err = {ab_unf | ba_unf, ab_ovf | ba_ovf};

endmodule

// File: tb/tb_tis_link.sv
module tb_tis_link;
  import tis_pkg::*;

  logic clk;
  logic rst_n;

  // DEPTH=1 instance
  word_t      d1_a_wdata, d1_b_wdata, d1_a_rdata, d1_b_rdata;
  logic       d1_a_write, d1_a_wready, d1_a_rready, d1_a_read;
  logic       d1_b_write, d1_b_wready, d1_b_rready, d1_b_read;
  logic [0:0] d1_ab_count, d1_ba_count;
  logic [1:0] d1_err;

  // DEPTH=4 instance
  word_t      a_wdata, b_wdata, a_rdata, b_rdata;
  logic       a_write, a_wready, a_rready, a_read;
  logic       b_write, b_wready, b_rready, b_read;
  logic [2:0] ab_count, ba_count;
  logic [1:0] err;

  int errors = 0;
  int checks = 0;

  tis_link #(.DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_wdata(d1_a_wdata), .a_write(d1_a_write), .a_wready(d1_a_wready),
    .a_rdata(d1_a_rdata), .a_rready(d1_a_rready), .a_read(d1_a_read),
    .b_wdata(d1_b_wdata), .b_write(d1_b_write), .b_wready(d1_b_wready),
    .b_rdata(d1_b_rdata), .b_rready(d1_b_rready), .b_read(d1_b_read),
    .ab_count(d1_ab_count), .ba_count(d1_ba_count), .err(d1_err)
  );

  tis_link #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a_wdata(a_wdata), .a_write(a_write), .a_wready(a_wready),
    .a_rdata(a_rdata), .a_rready(a_rready), .a_read(a_read),
    .b_wdata(b_wdata), .b_write(b_write), .b_wready(b_wready),
    .b_rdata(b_rdata), .b_rready(b_rready), .b_read(b_read),
    .ab_count(ab_count), .ba_count(ba_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then examined 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input word_t v);
    a_wdata = v;
    a_write = 1'b1;
    step();
    a_write = 1'b0;
    $display("write A->B %0d", v);
  endtask

  task automatic read_b();
    b_read = 1'b1;
    step();
    b_read = 1'b0;
    $display("read  A->B");
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (a_wready !== 1'b1 || b_wready !== 1'b1) begin
      errors++;
      $display("FAIL reset_wready: got a=%b b=%b want 1 1", a_wready, b_wready);
    end
    checks++;
    if (a_rready !== 1'b0 || b_rready !== 1'b0 || a_rdata !== 11'sd0 || b_rdata !== 11'sd0) begin
      errors++;
      $display("FAIL reset_rready: got a=%b b=%b ad=%0d bd=%0d want 0 0 0 0",
               a_rready, b_rready, a_rdata, b_rdata);
    end
    checks++;
    if (ab_count !== 3'd0 || ba_count !== 3'd0 || err !== 2'b00 || d1_err !== 2'b00) begin
      errors++;
      $display("FAIL reset_counts: got ab=%0d ba=%0d err=%b d1err=%b want 0 0 00 00",
               ab_count, ba_count, err, d1_err);
    end
    $display("reset done");
  endtask

  task automatic test_depth1();
    d1_a_wdata = 11'sd42;
    d1_a_write = 1'b1;
    step();
    d1_a_write = 1'b0;
    $display("d1 write A->B 42");
    checks++;
    if (d1_b_rready !== 1'b1 || d1_b_rdata !== 11'sd42 || d1_a_wready !== 1'b0) begin
      errors++;
      $display("FAIL d1_write: got rready=%b rdata=%0d wready=%b want 1 42 0",
               d1_b_rready, d1_b_rdata, d1_a_wready);
    end
    d1_b_read = 1'b1;
    step();
    d1_b_read = 1'b0;
    $display("d1 read A->B");
    checks++;
    if (d1_b_rready !== 1'b0 || d1_a_wready !== 1'b1 || d1_b_rdata !== 11'sd0 ||
        d1_ab_count !== 1'd0) begin
      errors++;
      $display("FAIL d1_read: got rready=%b wready=%b rdata=%0d cnt=%0d want 0 1 0 0",
               d1_b_rready, d1_a_wready, d1_b_rdata, d1_ab_count);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) write_a(word_t'(i));
    checks++;
    if (a_wready !== 1'b0 || ab_count !== 3'd4 || b_rdata !== 11'sd1) begin
      errors++;
      $display("FAIL fill: got wready=%b cnt=%0d head=%0d want 0 4 1", a_wready, ab_count, b_rdata);
    end
    write_a(11'sd99);
    checks++;
    if (err !== 2'b01 || ab_count !== 3'd4) begin
      errors++;
      $display("FAIL overflow: got err=%b cnt=%0d want 01 4", err, ab_count);
    end
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (b_rdata !== word_t'(i)) begin
        errors++;
        $display("FAIL drain_order: got %0d want %0d", b_rdata, i);
      end
      read_b();
    end
    checks++;
    if (b_rready !== 1'b0 || b_rdata !== 11'sd0 || ab_count !== 3'd0 || a_wready !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got rready=%b rdata=%0d cnt=%0d wready=%b want 0 0 0 1",
               b_rready, b_rdata, ab_count, a_wready);
    end
  endtask

  task automatic test_saturation();
    word_t neg_code;
    neg_code = 11'b100_0000_0000; // -1024
    write_a(11'sd1020);
    write_a(neg_code);
    checks++;
    if (b_rdata !== 11'sd999) begin
      errors++;
      $display("FAIL sat_high: got %0d want 999", b_rdata);
    end
    read_b();
    checks++;
    if (b_rdata !== -11'sd999) begin
      errors++;
      $display("FAIL sat_low: got %0d want -999", b_rdata);
    end
    read_b();
  endtask

  task automatic test_simultaneous();
    a_wdata = 11'sd10; a_write = 1'b1;
    b_wdata = 11'sd5;  b_write = 1'b1;
    step();
    b_write = 1'b0;
    a_wdata = 11'sd20;
    step();
    a_write = 1'b0;
    $display("write A->B 10,20  B->A 5");
    checks++;
    if (ab_count !== 3'd2 || ba_count !== 3'd1) begin
      errors++;
      $display("FAIL sim_setup: got ab=%0d ba=%0d want 2 1", ab_count, ba_count);
    end
    a_wdata = 11'sd7; a_write = 1'b1;
    b_read  = 1'b1;
    b_wdata = 11'sd6; b_write = 1'b1;
    step();
    a_write = 1'b0; b_read = 1'b0; b_write = 1'b0;
    $display("write A->B 7 + read A->B, write B->A 6");
    checks++;
    if (ab_count !== 3'd2 || b_rdata !== 11'sd20) begin
      errors++;
      $display("FAIL sim_ab: got cnt=%0d head=%0d want 2 20", ab_count, b_rdata);
    end
    checks++;
    if (ba_count !== 3'd2 || a_rdata !== 11'sd5) begin
      errors++;
      $display("FAIL sim_ba: got cnt=%0d head=%0d want 2 5", ba_count, a_rdata);
    end
    read_b();
    checks++;
    if (b_rdata !== 11'sd7) begin
      errors++;
      $display("FAIL sim_order: got %0d want 7", b_rdata);
    end
    read_b();
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    $display("read  B->A");
    checks++;
    if (a_rdata !== 11'sd6 || ba_count !== 3'd1 || ab_count !== 3'd0) begin
      errors++;
      $display("FAIL sim_ba_order: got head=%0d ba=%0d ab=%0d want 6 1 0", a_rdata, ba_count, ab_count);
    end
    a_read = 1'b1;
    step();
    a_read = 1'b0;
    $display("read  B->A");
  endtask

  task automatic test_underflow_reset();
    read_b();
    checks++;
    if (err !== 2'b11 || ab_count !== 3'd0 || ba_count !== 3'd0) begin
      errors++;
      $display("FAIL underflow: got err=%b ab=%0d ba=%0d want 11 0 0", err, ab_count, ba_count);
    end
    write_a(11'sd1);
    write_a(11'sd2);
    write_a(11'sd3);
    checks++;
    if (ab_count !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d want 3", ab_count);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("async reset asserted");
    checks++;
    if (ab_count !== 3'd0 || err !== 2'b00 || b_rready !== 1'b0 || b_rdata !== 11'sd0 ||
        a_wready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got cnt=%0d err=%b rready=%b rdata=%0d wready=%b want 0 00 0 0 1",
               ab_count, err, b_rready, b_rdata, a_wready);
    end
    step();
    rst_n = 1'b1;
    step();
    write_a(-11'sd55);
    checks++;
    if (b_rdata !== -11'sd55 || ab_count !== 3'd1) begin
      errors++;
      $display("FAIL post_reset: got head=%0d cnt=%0d want -55 1", b_rdata, ab_count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_wdata = '0; a_write = 1'b0; a_read = 1'b0;
    b_wdata = '0; b_write = 1'b0; b_read = 1'b0;
    d1_a_wdata = '0; d1_a_write = 1'b0; d1_a_read = 1'b0;
    d1_b_wdata = '0; d1_b_write = 1'b0; d1_b_read = 1'b0;
    test_reset();
    test_depth1();
    test_fill_overflow();
    test_saturation();
    test_simultaneous();
    test_underflow_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
